// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage data memory: op encodings, FSM states,
// and lane-enable / address-legality helpers also used by E-stage exception logic.
package mem_pkg;

   typedef enum logic [2:0] {
      OP_LW  = 3'b000,
      OP_LH  = 3'b001,
      OP_LHU = 3'b010,
      OP_LB  = 3'b011,
      OP_LBU = 3'b100,
      OP_SW  = 3'b101,
      OP_SH  = 3'b110,
      OP_SB  = 3'b111
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } mem_state_e;

   function automatic logic is_store(input mem_op_e op);
      return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
   endfunction

   function automatic logic [3:0] lane_en(input mem_op_e op, input logic [1:0] off);
      logic [3:0] be;
      case (op)
         OP_SW:   be = 4'b1111;
         OP_SH:   be = off[1] ? 4'b1100 : 4'b0011;
         OP_SB:   be = 4'b0001 << off;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic addr_illegal(input mem_op_e op, input logic [31:0] addr,
                                         input int unsigned addr_w);
      logic misal;
      case (op)
         OP_LW, OP_SW:         misal = (addr[1:0] != 2'b00);
         OP_LH, OP_LHU, OP_SH: misal = addr[0];
         default:              misal = 1'b0;
      endcase
      return misal || ((addr >> (addr_w + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane steering: store byte enables and lane-replicated
// write data, plus load extraction with sign/zero extension.
module mem_byte_lane
   import mem_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] word_i,
   output logic [3:0]  be_o,
   output logic [31:0] wlane_o,
   output logic [31:0] rext_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      be_o     = lane_en(mem_op_e'(op_i), off_i);
      byte_sel = word_i[{off_i, 3'b000} +: 8];
      half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

      // Replicating sub-word data places it in every lane; be_o picks the live one.
      case (mem_op_e'(op_i))
         OP_SH:   wlane_o = {2{wdata_i[15:0]}};
         OP_SB:   wlane_o = {4{wdata_i[7:0]}};
         default: wlane_o = wdata_i;
      endcase

      case (mem_op_e'(op_i))
         OP_LB:   rext_o = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  rext_o = {24'd0, byte_sel};
         OP_LH:   rext_o = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  rext_o = {16'd0, half_sel};
         default: rext_o = word_i;
      endcase
   end

endmodule

// File: rtl/data_mem_unit.sv
// M-stage data memory with configurable access latency, request/stall/done
// handshake, address-error detection and a store trace.
module data_mem_unit
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned LATENCY = 1
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        req,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [31:0] pc,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        done,
   output logic        exc_adel,
   output logic        exc_ades
);

   localparam int unsigned CW    = $clog2(LATENCY + 1);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   mem_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     data_q;
   logic [2:0]      op_q;
   logic [1:0]      off_q;
   logic [31:0]     mem_q [DEPTH];

   logic [ADDR_W-1:0] idx;
   logic              illegal, st, access;
   logic [2:0]        op_sel;
   logic [1:0]        off_sel;
   logic [31:0]       word_sel, wlane, rext, merged;
   logic [3:0]        be;

   assign idx     = addr[ADDR_W+1:2];
   assign illegal = addr_illegal(mem_op_e'(op), addr, ADDR_W);
   assign st      = is_store(mem_op_e'(op));

   // In RESP the lane unit extracts from the captured word; otherwise it steers the store.
   assign op_sel   = (state_q == ST_RESP) ? op_q   : op;
   assign off_sel  = (state_q == ST_RESP) ? off_q  : addr[1:0];
   assign word_sel = (state_q == ST_RESP) ? data_q : mem_q[idx];

   mem_byte_lane u_lane (
      .op_i    (op_sel),
      .off_i   (off_sel),
      .wdata_i (wdata),
      .word_i  (word_sel),
      .be_o    (be),
      .wlane_o (wlane),
      .rext_o  (rext)
   );

   always_comb begin
      for (int unsigned i = 0; i < 4; i++)
         merged[8*i +: 8] = be[i] ? wlane[8*i +: 8] : word_sel[8*i +: 8];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall    = 1'b0;
      access   = 1'b0;
      exc_adel = 1'b0;
      exc_ades = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (illegal) begin
                  exc_adel = ~st;
                  exc_ades = st;
               end else begin
                  stall = 1'b1;
                  if (LATENCY == 1) begin
                     access  = 1'b1;
                     state_d = ST_RESP;
                  end else begin
                     cnt_d   = CW'(LATENCY - 1);
                     state_d = ST_WAIT;
                  end
               end
            end
         end
         ST_WAIT: begin
            stall = 1'b1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               access  = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign done  = (state_q == ST_RESP);
   assign rdata = done ? rext : '0;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         op_q    <= '0;
         off_q   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++)
            mem_q[ADDR_W'(i)] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (access) begin
            op_q  <= op;
            off_q <= addr[1:0];
            if (st) begin
               mem_q[idx] <= merged;
`ifndef SYNTHESIS
               $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
`endif
            end else begin
               data_q <= mem_q[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit at LATENCY=1 and LATENCY=3.
module tb_data_mem_unit;

   localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                          LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        rst1, req1, rst3, req3;
   logic [2:0]  op1, op3;
   logic [31:0] addr1, wdata1, pc1, addr3, wdata3, pc3;
   logic [31:0] rdata1, rdata3;
   logic        stall1, done1, adel1, ades1;
   logic        stall3, done3, adel3, ades3;

   data_mem_unit #(.ADDR_W(12), .LATENCY(1)) u_dut1 (
      .CLK(CLK), .Reset(rst1), .req(req1), .op(op1), .addr(addr1), .wdata(wdata1),
      .pc(pc1), .rdata(rdata1), .stall(stall1), .done(done1),
      .exc_adel(adel1), .exc_ades(ades1));

   data_mem_unit #(.ADDR_W(12), .LATENCY(3)) u_dut3 (
      .CLK(CLK), .Reset(rst3), .req(req3), .op(op3), .addr(addr3), .wdata(wdata3),
      .pc(pc3), .rdata(rdata3), .stall(stall3), .done(done3),
      .exc_adel(adel3), .exc_ades(ades3));

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned sel = 1;
   logic [31:0] exp_q [$];

   logic [31:0] o_rdata;
   logic        o_stall, o_done, o_adel, o_ades;
   always_comb begin
      o_rdata = (sel == 3) ? rdata3 : rdata1;
      o_stall = (sel == 3) ? stall3 : stall1;
      o_done  = (sel == 3) ? done3  : done1;
      o_adel  = (sel == 3) ? adel3  : adel1;
      o_ades  = (sel == 3) ? ades3  : ades1;
   end

   task automatic drive(input logic r, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] w);
      if (sel == 3) begin
         req3 = r; op3 = o; addr3 = a; wdata3 = w; pc3 = 32'h0040_0000 + a;
      end else begin
         req1 = r; op1 = o; addr1 = a; wdata1 = w; pc1 = 32'h0040_0000 + a;
      end
   endtask

   task automatic go_idle();
      @(posedge CLK); #1 drive(1'b0, LW, 32'd0, 32'd0);
   endtask

   // Requests are issued on the edge right after the previous done: back-to-back.
   task automatic access(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] w, input logic [31:0] exp_rd,
                         input int unsigned lat);
      int unsigned stalls = 0;
      logic        got = 1'b0;
      logic        ld;
      logic [31:0] e;
      ld = (o < SW);
      if (ld) exp_q.push_back(exp_rd);
      @(posedge CLK); #1 drive(1'b1, o, a, w);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge CLK);
         if (o_done === 1'b1) got = 1'b1;
         else if (o_stall === 1'b1) stalls++;
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL %s done: got no done, required done within 20 cycles", name);
      end
      vectors++;
      if (stalls !== lat) begin
         miscompares++;
         $display("FAIL %s stall_cycles: got %0d, required %0d", name, stalls, lat);
      end
      vectors++;
      if (o_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL %s stall_at_done: got %b, required 0", name, o_stall);
      end
      if (ld) begin
         e = exp_q.pop_front();
         vectors++;
         if (o_rdata !== e) begin
            miscompares++;
            $display("FAIL %s rdata: got %h, required %h", name, o_rdata, e);
         end
      end
   endtask

   task automatic test_reset();
      rst1 = 1'b1; rst3 = 1'b1;
      sel = 1; drive(1'b0, LW, 32'd0, 32'd0);
      sel = 3; drive(1'b0, LW, 32'd0, 32'd0);
      repeat (2) @(posedge CLK);
      #1 rst1 = 1'b0; rst3 = 1'b0;
      @(negedge CLK);
      for (int unsigned d = 1; d <= 3; d += 2) begin
         sel = d;
         #0;
         vectors++;
         if ({o_rdata, o_stall, o_done, o_adel, o_ades} !== 36'd0) begin
            miscompares++;
            $display("FAIL reset_outputs_dut%0d: got rdata=%h stall=%b done=%b adel=%b ades=%b, required all 0",
                     d, o_rdata, o_stall, o_done, o_adel, o_ades);
         end
      end
   endtask

   task automatic test_lat1_word();
      sel = 1;
      access("sw_0x10", SW, 32'h10, 32'h1122_3344, 32'd0, 1);
      access("lw_0x10", LW, 32'h10, 32'd0, 32'h1122_3344, 1);
      access("sb_0x13", SB, 32'h13, 32'h0000_00AB, 32'd0, 1);
      access("lw_0x10_merged", LW, 32'h10, 32'd0, 32'hAB22_3344, 1);
      go_idle();
   endtask

   task automatic test_extend();
      sel = 1;
      access("sw_0x20", SW, 32'h20, 32'h80FF_7F01, 32'd0, 1);
      access("lb_0x22",  LB,  32'h22, 32'd0, 32'hFFFF_FFFF, 1);
      access("lbu_0x22", LBU, 32'h22, 32'd0, 32'h0000_00FF, 1);
      access("lh_0x22",  LH,  32'h22, 32'd0, 32'hFFFF_80FF, 1);
      access("lhu_0x20", LHU, 32'h20, 32'd0, 32'h0000_7F01, 1);
      access("lb_0x21",  LB,  32'h21, 32'd0, 32'h0000_007F, 1);
      go_idle();
   endtask

   task automatic check_illegal(input string name, input logic [2:0] o, input logic [31:0] a);
      logic st;
      st = (o >= SW);
      @(posedge CLK); #1 drive(1'b1, o, a, 32'hFFFF_FFFF);
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         vectors++;
         if ({o_adel, o_ades, o_stall, o_done} !== {~st, st, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL %s cycle%0d: got adel=%b ades=%b stall=%b done=%b, required adel=%b ades=%b stall=0 done=0",
                     name, c, o_adel, o_ades, o_stall, o_done, ~st, st);
         end
      end
      go_idle();
   endtask

   task automatic test_illegal();
      sel = 1;
      check_illegal("lh_0x1001", LH, 32'h1001);
      check_illegal("sw_0x1002", SW, 32'h1002);
      check_illegal("lw_0x4000", LW, 32'h4000);
      check_illegal("sb_high",   SB, 32'h8000_0010);
      access("lw_0x1000_unchanged", LW, 32'h1000, 32'd0, 32'd0, 1);
      go_idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] model [4];
      sel = 1;
      for (int i = 0; i < 4; i++) begin
         model[i] = $urandom();
         access("b2b_sw", SW, 32'h100 + 32'(4*i), model[i], 32'd0, 1);
      end
      for (int i = 0; i < 4; i++)
         access("b2b_lw", LW, 32'h100 + 32'(4*i), 32'd0, model[i], 1);
      go_idle();
   endtask

   task automatic test_lat3();
      sel = 3;
      access("l3_sh_0x30",  SH,  32'h30, 32'h0000_BEEF, 32'd0, 3);
      access("l3_lw_0x30",  LW,  32'h30, 32'd0, 32'h0000_BEEF, 3);
      access("l3_sb_0x32",  SB,  32'h32, 32'h0000_0012, 32'd0, 3);
      access("l3_lhu_0x32", LHU, 32'h32, 32'd0, 32'h0000_0012, 3);
      go_idle();
   endtask

   task automatic test_reset_abort();
      sel = 3;
      @(posedge CLK); #1 drive(1'b1, SW, 32'h40, 32'hDEAD_BEEF);
      @(posedge CLK); #1;
      @(posedge CLK); #1 rst3 = 1'b1;
      @(negedge CLK);
      vectors++;
      if (o_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_second_wait_stall: got %b, required 1", o_stall);
      end
      @(posedge CLK); #1 rst3 = 1'b0; drive(1'b0, LW, 32'd0, 32'd0);
      @(negedge CLK);
      vectors++;
      if ({o_stall, o_done, o_rdata} !== 34'd0) begin
         miscompares++;
         $display("FAIL abort_after_reset: got stall=%b done=%b rdata=%h, required 0 0 0",
                  o_stall, o_done, o_rdata);
      end
      access("abort_lw_0x40", LW, 32'h40, 32'd0, 32'd0, 3);
      go_idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_lat1_word();
      test_extend();
      test_illegal();
      test_back_to_back();
      test_lat3();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised data-memory unit for the M stage, replacing the single-cycle word memory plus read-modify-write store merger. It supports all MIPS load/store widths with per-byte write enables and load sign/zero extension. It detects misaligned or out-of-range accesses and models a configurable access latency through a request/stall/done handshake to the pipeline. Sits between the M-stage forwarding mux (store data) and the W-stage pipeline register (load data).

## Interface
Parameters:
- ADDR_W, 12, word-address bits; memory holds 2^ADDR_W 32-bit words.
- LATENCY, 1, cycles from request acceptance to access (must be ≥1).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- req  in  1  M-stage instruction is a load/store; held high by the pipeline while stalled.
- op  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
- addr  in  32  byte address (ALU output).
- wdata  in  32  forwarded rt value; sub-word data in low bits.
- pc  in  32  address of the M-stage instruction, used for the write trace.
- rdata  out  32  extended load result, valid while done=1.
- stall  out  1  freeze F/D/E/M and bubble W.
- done  out  1  access complete this cycle; pipeline advances at the next edge.
- exc_adel  out  1  load address error.
- exc_ades  out  1  store address error.

## Operation
- FSM states: IDLE, WAIT, RESP. The counter is ceil(log2(LATENCY+1)) bits wide.
- IDLE, req=1, legal address: stall=1.
  - LATENCY=1: next state RESP, and the access is performed at this edge.
  - LATENCY>1: load counter=LATENCY-1 and go to WAIT.
- WAIT: stall=1. Decrement the counter each cycle. When the counter reaches 1, perform the access at that edge and go to RESP.
- Access edge:
  - Stores write only the enabled byte lanes.
    - sw: all four lanes.
    - sh: lanes {1,0} if addr[1]=0, else {3,2}.
    - sb: lane addr[1:0].
  - Loads capture the whole word into a data register.
  - Memory index is addr[ADDR_W+1:2].
- RESP: done=1, stall=0. rdata = the captured word extracted by addr[1:0] (held stable by the stalled pipeline):
  - lb/lh: sign-extend.
  - lbu/lhu: zero-extend.
  - lw: unchanged.
  - Next state is IDLE unconditionally. req in RESP belongs to the completing instruction and is ignored.
- Illegal access is checked only in IDLE, combinationally. Illegal means either:
  - lw/sw with addr[1:0]≠0, or lh/lhu/sh with addr[0]≠0, or
  - addr[31:ADDR_W+2]≠0.
- On an illegal access:
  - exc_adel (loads) or exc_ades (stores) =1 that cycle.
  - stall=0, no memory write, state stays IDLE.
- Store trace: at each write edge, print the line "%d@%h: *%h <= %h" with $time, pc, {addr[31:2],2'b00}, and the resulting full word after lane merge.
- Reset (any state):
  - FSM→IDLE, counter→0, data register→0, all memory words→0.
  - An in-flight access is abandoned with no write, even if this cycle would have been the access edge.
- Outputs in reset/IDLE without req: rdata=0, stall=0, done=0, exc_adel=0, exc_ades=0.

## Timing
- Legal access occupies LATENCY+1 cycles: LATENCY stall cycles, then one done cycle.
- stall and exc_* are combinational from state, req, op and addr. done and rdata depend only on registered state.
- Back-to-back accesses: RESP→IDLE, so the next request is accepted in the cycle after done. Minimum spacing is LATENCY+1 cycles.
- The write occurs exactly once per legal store, at the WAIT/IDLE→RESP edge.

## Structure
- Shared package (mem_pkg): op encodings, FSM state encoding, and lane-enable/illegal-address functions reused by the E-stage exception logic.
- One combinational sub-module, mem_byte_lane:
  - inputs op, addr[1:0], wdata, word;
  - outputs byte-enable[3:0], lane-aligned write data, and extended load data.
- The FSM, counter, memory array and trace stay in data_mem_unit.

## Test plan
- LATENCY=1: sw 0x11223344 to 0x10, then lw 0x10. Each access gives stall for 1 cycle then done; rdata=0x11223344.
- After the above, sb wdata=0x000000AB at 0x13, then lw 0x10 → 0xAB223344. Trace word=0xAB223344.
- Word 0x80FF7F01 at 0x20:
  - lb 0x22 → 0xFFFFFFFF; lbu 0x22 → 0x000000FF;
  - lh 0x22 → 0xFFFF80FF; lhu 0x20 → 0x00007F01.
- Illegal addresses:
  - lh 0x1001 → exc_adel=1, stall=0, state IDLE.
  - sw 0x1002 → exc_ades=1, memory unchanged.
  - lw 0x4000 with ADDR_W=12 → exc_adel=1.
- LATENCY=3: sh wdata=0xBEEF at 0x30 gives stall high 3 cycles, done on the 4th cycle. Word at 0x30 becomes 0x0000BEEF.
- LATENCY=3: Reset asserted in the second WAIT cycle of sw 0xDEADBEEF at 0x40.
  - Next cycle: IDLE, stall=0, done=0.
  - lw 0x40 afterwards → 0x00000000; no trace line printed.
